// File: rtl/router_pkg.sv
// Shared mesh-router definitions.
// Holds the one-hot direction identities, the req/grant bit indices and the default flit width
// used by every router port.
package router_pkg;

  localparam int unsigned NumPorts  = 5;
  localparam int unsigned FlitWidth = 64;

  // One-hot direction identities; also the grant pattern selecting that input.
  localparam logic [NumPorts-1:0] DIR_L  = 5'b10000;
  localparam logic [NumPorts-1:0] DIR_R  = 5'b01000;
  localparam logic [NumPorts-1:0] DIR_U  = 5'b00100;
  localparam logic [NumPorts-1:0] DIR_D  = 5'b00010;
  localparam logic [NumPorts-1:0] DIR_PE = 5'b00001;

  // Bit positions inside req/grant.
  localparam int unsigned IdxL  = 4;
  localparam int unsigned IdxR  = 3;
  localparam int unsigned IdxU  = 2;
  localparam int unsigned IdxD  = 1;
  localparam int unsigned IdxPE = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Five-way round-robin arbiter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (priority returns to L)
//   en        - arbitration allowed (FIFO has room and not in reset)
//   req       - request vector, bit4 L .. bit0 PE
//   grant     - one-hot grant, combinational from req and the priority register
// Scanning starts at the priority bit and moves toward bit0, wrapping to bit4. After a grant the
// priority moves to the bit just below the winner.
module rr_arbiter
  import router_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NumPorts-1:0] req,
  output logic [NumPorts-1:0] grant
);

  logic [NumPorts-1:0] prio_q, prio_d;
  logic                armed;
  logic                found;

  // Walk the ports twice from high to low. Arming on the priority bit during the first pass makes
  // the scan begin there; the second pass provides the bit0 -> bit4 wrap.
  always_comb begin
    grant = '0;
    armed = 1'b0;
    found = 1'b0;
    for (int n = 2 * NumPorts - 1; n >= 0; n--) begin
      if (n >= int'(NumPorts) && prio_q[n % NumPorts]) begin
        armed = 1'b1;
      end
      if (en && armed && !found && req[n % NumPorts]) begin
        grant[n % NumPorts] = 1'b1;
        found               = 1'b1;
      end
    end
  end

  // Rotate right: the bit after the winner in scan order, bit0 wrapping to bit4.
  always_comb begin
    prio_d = prio_q;
    if (found) begin
      prio_d = {grant[0], grant[NumPorts-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= DIR_L;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/output_interface.sv
// Mesh-router output port.
// Arbitrates round-robin among the five input interfaces requesting this direction and moves the
// winning flit into a small FIFO that drives the send/ready handshake downstream.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req                   - per-input requests, bit4 L, bit3 R, bit2 U, bit1 D, bit0 PE
//   dataiL .. dataiPE     - flit offered by each input interface
//   ro                    - downstream ready
//   grant                 - one-hot grant; also the buffer-clear pulse to the winning input
//   so                    - FIFO holds a valid flit
//   datao                 - flit at the FIFO head
module output_interface
  import router_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH   = FlitWidth,
  parameter logic [NumPorts-1:0] DIRECTION    = DIR_PE,
  parameter int unsigned         BUFFER_DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NumPorts-1:0]   req,
  input  logic [DATA_WIDTH-1:0] dataiL,
  input  logic [DATA_WIDTH-1:0] dataiR,
  input  logic [DATA_WIDTH-1:0] dataiU,
  input  logic [DATA_WIDTH-1:0] dataiD,
  input  logic [DATA_WIDTH-1:0] dataiPE,
  input  logic                  ro,
  output logic [NumPorts-1:0]   grant,
  output logic                  so,
  output logic [DATA_WIDTH-1:0] datao
);

  localparam int unsigned PtrW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUFFER_DEPTH + 1);

  // DIRECTION only names the port; it does not steer any logic.
  logic unused_direction;
  assign unused_direction = ^DIRECTION;

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUFFER_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  full;
  logic                  push;
  logic                  pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BUFFER_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full = (count_q == CntW'(BUFFER_DEPTH));

  // No grant when full even if a pop happens this cycle, and none while in reset.
  rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (!full && !rst),
    .req   (req),
    .grant (grant)
  );

  assign push  = |grant;
  assign so    = (count_q != '0);
  assign pop   = so && ro;
  assign datao = mem_q[rd_ptr_q];

  always_comb begin
    push_data = '0;
    unique case (grant)
      DIR_L:   push_data = dataiL;
      DIR_R:   push_data = dataiR;
      DIR_U:   push_data = dataiU;
      DIR_D:   push_data = dataiD;
      DIR_PE:  push_data = dataiPE;
      default: push_data = '0;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_output_interface.sv
// Bench for output_interface: three instances (depth 1, 2, 4) with private req/ro/rst and shared
// data buses. Grants are checked as stimulus is applied; delivered flits are checked by a
// per-instance monitor popping an expected-flit queue on every so && ro handshake.
module tb_output_interface;

  logic        clk = 1'b0;
  logic [63:0] dataiL, dataiR, dataiU, dataiD, dataiPE;
  logic        rst   [3];
  logic [4:0]  req   [3];
  logic        ro    [3];
  logic [4:0]  grant [3];
  logic        so    [3];
  logic [63:0] datao [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    output_interface #(
      .DATA_WIDTH   (64),
      .DIRECTION    (5'b00001),
      .BUFFER_DEPTH ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .req     (req[g]),
      .dataiL  (dataiL),
      .dataiR  (dataiR),
      .dataiU  (dataiU),
      .dataiD  (dataiD),
      .dataiPE (dataiPE),
      .ro      (ro[g]),
      .grant   (grant[g]),
      .so      (so[g]),
      .datao   (datao[g])
    );

    logic [63:0] exp_q[$];

    always @(negedge clk) begin
      if (so[g] === 1'b1 && ro[g] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL flit_dut%0d: got %h, required no flit (nothing expected)", g, datao[g]);
        end else begin
          check($sformatf("flit_dut%0d", g), datao[g], exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  rr_exp [6];
    logic [63:0] rr_dat [6];

    dataiL  = 64'h1111_0000_0000_0001;
    dataiR  = 64'h2222_0000_0000_0002;
    dataiU  = 64'h3333_0000_0000_0003;
    dataiD  = 64'h4444_0000_0000_0004;
    dataiPE = 64'h5555_0000_0000_0005;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      req[d] = 5'b00000;
      ro[d]  = 1'b0;
    end

    // Reset held two cycles with all requests raised on the depth-1 port.
    req[0] = 5'b11111;
    for (int c = 0; c < 2; c++) begin
      cyc();
      #1;
      check("rst_grant", grant[0], 5'b00000);
      check("rst_so", so[0], 1'b0);
      check("rst_datao", datao[0], 64'h0);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    #1;
    check("first_grant_L", grant[0], 5'b10000);
    g_dut[0].exp_q.push_back(dataiL);
    cyc();
    req[0] = 5'b00000;
    #1;
    check("so_after_push", so[0], 1'b1);
    ro[0] = 1'b1;
    cyc();
    ro[0] = 1'b0;

    // Single flit through the depth-1 port.
    dataiU = 64'hA5A5_0000_0000_0001;
    req[0] = 5'b00100;
    #1;
    check("u_grant", grant[0], 5'b00100);
    g_dut[0].exp_q.push_back(dataiU);
    cyc();
    #1;
    check("u_so", so[0], 1'b1);
    check("u_datao", datao[0], 64'hA5A5_0000_0000_0001);
    check("u_full_nogrant", grant[0], 5'b00000);
    req[0] = 5'b00000;
    ro[0]  = 1'b1;
    cyc();
    #1;
    check("u_so_fall", so[0], 1'b0);
    ro[0] = 1'b0;

    // Round-robin on the depth-4 port with all requests held and ro high.
    rr_exp = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
    rr_dat = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002, 64'hA5A5_0000_0000_0001,
               64'h4444_0000_0000_0004, 64'h5555_0000_0000_0005, 64'h1111_0000_0000_0001};
    req[2] = 5'b11111;
    ro[2]  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), grant[2], rr_exp[i]);
      g_dut[2].exp_q.push_back(rr_dat[i]);
      cyc();
    end
    req[2] = 5'b00000;
    cyc();
    #1;
    check("rr_drained", so[2], 1'b0);
    ro[2] = 1'b0;

    // Depth-2 port fills, refuses while full (no bypass), then regrants after a pop.
    req[1]  = 5'b00001;
    dataiPE = 64'hF1F1_0000_0000_00F1;
    #1;
    check("full_g1", grant[1], 5'b00001);
    g_dut[1].exp_q.push_back(dataiPE);
    cyc();
    dataiPE = 64'hF2F2_0000_0000_00F2;
    #1;
    check("full_g2", grant[1], 5'b00001);
    g_dut[1].exp_q.push_back(dataiPE);
    cyc();
    dataiPE = 64'hF3F3_0000_0000_00F3;
    ro[1]   = 1'b1;
    #1;
    check("full_nobypass", grant[1], 5'b00000);
    cyc();
    ro[1] = 1'b0;
    #1;
    check("full_regrant", grant[1], 5'b00001);
    g_dut[1].exp_q.push_back(dataiPE);
    cyc();
    req[1] = 5'b00000;
    ro[1]  = 1'b1;
    cyc();

    // Push and pop together at count 1.
    dataiR = 64'hB2B2_0000_0000_00B2;
    req[1] = 5'b01000;
    #1;
    check("pp_grant", grant[1], 5'b01000);
    g_dut[1].exp_q.push_back(dataiR);
    cyc();
    ro[1]  = 1'b0;
    dataiD = 64'hD4D4_0000_0000_00D4;
    req[1] = 5'b00010;
    #1;
    check("pp_so", so[1], 1'b1);
    check("pp_datao", datao[1], 64'hB2B2_0000_0000_00B2);
    check("pp_room", grant[1], 5'b00010);
    g_dut[1].exp_q.push_back(dataiD);
    cyc();
    #1;
    check("pp_full", grant[1], 5'b00000);

    // Reset mid-stream with two flits buffered; priority was PE before it.
    rst[1] = 1'b1;
    cyc();
    rst[1] = 1'b0;
    g_dut[1].exp_q.delete();
    req[1] = 5'b11111;
    #1;
    check("mid_rst_so", so[1], 1'b0);
    check("mid_rst_datao", datao[1], 64'h0);
    check("mid_rst_prio_L", grant[1], 5'b10000);
    g_dut[1].exp_q.push_back(dataiL);
    cyc();
    req[1] = 5'b00000;
    ro[1]  = 1'b1;
    cyc();
    ro[1] = 1'b0;
    cyc();

    for (int d = 0; d < 3; d++) begin
      case (d)
        0:       check("left_dut0", 64'(g_dut[0].exp_q.size()), 64'h0);
        1:       check("left_dut1", 64'(g_dut[1].exp_q.size()), 64'h0);
        default: check("left_dut2", 64'(g_dut[2].exp_q.size()), 64'h0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_interface.md
# output_interface

Output port of the mesh router, one per direction (L, R, U, D, PE). Collects the per-direction requests raised by the five input interfaces' routing stages, arbitrates round-robin among them, and moves the winning 64-bit flit into a small output FIFO. Drives the send/ready handshake toward the neighbouring router's input interface, or the local PE. The grant doubles as the buffer-clear pulse back to the winning input interface.

## Interface
- DATA_WIDTH, 64, flit width
- DIRECTION, 5'b00001, one-hot identity of this output (L:10000, R:01000, U:00100, D:00010, PE:00001); informational, no effect on logic
- BUFFER_DEPTH, 1, output FIFO depth in flits; legal values 1, 2, 4
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  5  request from each input interface targeting this output; bit4 L, bit3 R, bit2 U, bit1 D, bit0 PE
- dataiL, dataiR, dataiU, dataiD, dataiPE  in  DATA_WIDTH each  flit offered by the corresponding input interface
- ro  in  1  downstream ready: the neighbour's input channel can accept a flit this cycle
- grant  out  5  one-hot grant, same bit order as req; each bit drives the sig_buffer_clear of that input interface
- so  out  1  send: output FIFO holds a valid flit
- datao  out  DATA_WIDTH  flit at FIFO head

## Operation
- State: FIFO storage, rd/wr pointers (width max(1, clog2(BUFFER_DEPTH)), wrap modulo BUFFER_DEPTH), count (0..BUFFER_DEPTH), 5-bit one-hot priority pointer prio.
- Arbitration (combinational from registered state): when count < BUFFER_DEPTH and req != 0, grant the first asserted req bit found scanning from prio's position downward (bit4→bit0), wrapping bit0→bit4. Otherwise grant = 0.
- Grant is never given when FIFO is full, even if a pop occurs the same cycle (no full-bypass).
- Push: on an edge where grant != 0, the granted input's flit is written at wr pointer; wr pointer advances; prio becomes the bit immediately after the granted bit in scan order (grant bit0 → prio bit4).
- prio unchanged in cycles with no grant.
- Pop: on an edge where so && ro, rd pointer advances.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- so = (count != 0); datao = storage[rd]. datao is don't-care when so = 0 but must not be X after reset; storage is cleared on reset.
- Input interfaces hold req and data stable until granted; the block does not latch req.
- ro while so = 0 is ignored.

## Timing
- Reset (rst high at an edge): count 0, pointers 0, storage 0, prio = 5'b10000 (L first). During and after reset: grant 0 (count is 0 but the grant output is forced to 0 while rst is high), so 0, datao 0.
- Reset mid-operation discards all buffered flits; no grant is issued in the reset cycle.
- Grant latency: grant asserts combinationally in the same cycle the req is seen, provided the FIFO has space. The flit is captured at the next edge.
- Flit-in to so: so rises the cycle after the grant edge.
- Throughput: one push and one pop per cycle. With BUFFER_DEPTH = 1, the alternation is push, pop, push (max one flit per 2 cycles). Depth ≥ 2 sustains 1 flit/cycle when ro stays high.
- Simultaneous push and pop with count = BUFFER_DEPTH cannot occur (no grant when full). With 0 < count < BUFFER_DEPTH, both proceed and count holds.

## Structure
- Shared package router_pkg: direction one-hot constants (DIR_L, DIR_R, DIR_U, DIR_D, DIR_PE), the req/grant bit-index constants, the default flit width.
- Sub-module rr_arbiter (5-bit req, enable, prio register, one-hot grant). The FIFO stays inline.

## Test plan
- Reset: hold rst 2 cycles with req = 5'b11111 → grant 0, so 0, datao 0 throughout; first cycle after reset with req = 5'b11111 → grant 5'b10000.
- Single flit, depth 1: req = 5'b00100, dataiU = 64'hA5A5_0000_0000_0001, ro = 0 → grant 5'b00100 for 1 cycle; next cycle so = 1, datao = that value, grant 0 despite req; raise ro → so falls the following cycle.
- Round-robin fairness: all five req held, ro = 1, depth 4 → grant order 10000, 01000, 00100, 00010, 00001, 10000.
- Full FIFO: depth 2, ro = 0, req = 5'b00001 with two distinct flits → two grants, then grant 0. Set ro = 1 for one cycle → one pop, count 1, next grant allowed the cycle after.
- Simultaneous push/pop: depth 2, count 1, ro = 1, req = 5'b01000 → grant asserted, count stays 1, datao advances to the new flit next cycle.
- Reset mid-stream: count 2, assert rst 1 cycle → so 0 next cycle; after reset, prio = L.
